// File: rtl/uart_prog_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
//   LOADER_HDR / LOADER_ACK / LOADER_NAK : frame header and reply bytes
//   loader_state_e : frame FSM encoding (3-bit)
//   rx_state_e     : UART receiver bit-timing FSM encoding
package uart_prog_loader_pkg;

  localparam int unsigned MEM_ADDR_W   = 32;
  localparam int unsigned MEM_W        = 32;
  localparam logic        WRITE_ENABLE = 1'b1;

  localparam logic [7:0] LOADER_HDR = 8'hA5;
  localparam logic [7:0] LOADER_ACK = 8'h06;
  localparam logic [7:0] LOADER_NAK = 8'h15;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAddr = 3'd1,
    StCnt  = 3'd2,
    StData = 3'd3,
    StCsum = 3'd4
  } loader_state_e;

  typedef enum logic [1:0] {
    RxIdle  = 2'd0,
    RxStart = 2'd1,
    RxData  = 2'd2,
    RxStop  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-FF input synchronizer.
// Ports:
//   clk, rst (async, active-low)
//   rx         : serial line, idle high, asynchronous to clk
//   byte_valid : 1-cycle pulse, one cycle after a good stop-bit sample
//   byte_data  : received byte, valid with byte_valid
//   frame_err  : 1-cycle pulse when the stop bit sampled low (byte dropped)
module uart_rx
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(BAUD_DIV) + 1;
  localparam logic [CntW-1:0] HalfM1 = CntW'(BAUD_DIV / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(BAUD_DIV - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RxIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d = '0;
          bit_d = '0;
          // Line back high at mid-start means a glitch, not a start bit.
          state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (cnt_q == FullM1) begin
          cnt_d = '0;
          sh_d  = {rx_sync_q, sh_q[7:1]};
          if (bit_q == 3'd7) state_d = RxStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxStop: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          valid_d = rx_sync_q;
          ferr_d  = !rx_sync_q;
          state_d = RxIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = sh_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: receives framed program images over UART and writes
// little-endian 32-bit words to the instruction ROM write port.
// Frame: A5 | ADDR[4] LE | CNT[2] LE | DATA[4*CNT] | CSUM (XOR of bytes after A5).
// Optional feature macro LOADER_TX_ACK_EN: builds an 8N1 TX that replies ACK (06)
// on a good frame or NAK (15) on abort/checksum error; otherwise tx_o is tied to 1.
// Ports:
//   clk, rst (async, active-low), rx_i : UART RX line
//   tx_o   : UART TX line (ACK/NAK)
//   we_o, addr_o, data_o : ROM write port, one single-cycle pulse per word
//   busy_o : frame in progress (holds the core in halt)
//   done_o : 1-cycle pulse on a frame with a good checksum
//   err_o  : sticky error, cleared by the next accepted header byte
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned BYTE_TIMEOUT = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_i,
  output logic                  tx_o,
  output logic                  we_o,
  output logic [MEM_ADDR_W-1:0] addr_o,
  output logic [MEM_W-1:0]      data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned ToW      = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(BYTE_TIMEOUT - 1);

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  uart_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx_i),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  loader_state_e   state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     sh_q, sh_d, sh_nxt;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     word_q, word_d;
  logic [7:0]      csum_q, csum_d;
  logic [ToW-1:0]  to_q, to_d;
  logic            we_q, we_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            nak_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      to_q    <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      to_q    <= to_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Incoming bytes shift in from the top so four of them form a LE word.
  assign sh_nxt = {byte_data, sh_q[31:8]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    nak_d   = 1'b0;
    to_d    = (state_q == StIdle || byte_valid) ? '0 : to_q + ToW'(1);

    // Address advances the cycle after the write pulse, so it is stable during it.
    if (we_q) addr_d = addr_q + 32'd4;

    unique case (state_q)
      StIdle: begin
        if (byte_valid && byte_data == LOADER_HDR) begin
          state_d = StAddr;
          err_d   = 1'b0;
          csum_d  = '0;
          idx_d   = '0;
        end
      end
      StAddr: begin
        if (byte_valid) begin
          csum_d = csum_q ^ byte_data;
          sh_d   = sh_nxt;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            addr_d  = {sh_nxt[31:2], 2'b00};
            idx_d   = '0;
            state_d = StCnt;
          end
        end
      end
      StCnt: begin
        if (byte_valid) begin
          csum_d = csum_q ^ byte_data;
          sh_d   = sh_nxt;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd1) begin
            cnt_d   = sh_nxt[31:16];
            word_d  = '0;
            idx_d   = '0;
            state_d = (sh_nxt[31:16] == 16'd0) ? StCsum : StData;
          end
        end
      end
      StData: begin
        if (byte_valid) begin
          csum_d = csum_q ^ byte_data;
          sh_d   = sh_nxt;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            data_d = sh_nxt;
            we_d   = WRITE_ENABLE;
            idx_d  = '0;
            word_d = word_q + 16'd1;
            if (word_q + 16'd1 == cnt_q) state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (byte_valid) begin
          state_d = StIdle;
          if (byte_data == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
            nak_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort: framing error or inter-byte timeout anywhere inside a frame.
    if (state_q != StIdle && (frame_err || (!byte_valid && to_q == ToLast))) begin
      state_d = StIdle;
      err_d   = 1'b1;
      nak_d   = 1'b1;
    end
  end

  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign err_o  = err_q;

`ifdef LOADER_TX_ACK_EN
  localparam int unsigned TxCntW = $clog2(BAUD_DIV) + 1;
  localparam logic [TxCntW-1:0] TxFullM1 = TxCntW'(BAUD_DIV - 1);

  logic [9:0]        tx_sh_q;
  logic [3:0]        tx_bit_q;
  logic [TxCntW-1:0] tx_cnt_q;
  logic              tx_busy_q;

  // Requests arriving while a reply is still shifting out are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_sh_q   <= '1;
      tx_bit_q  <= '0;
      tx_cnt_q  <= '0;
      tx_busy_q <= 1'b0;
    end else if (!tx_busy_q) begin
      if (done_d || nak_d) begin
        tx_sh_q   <= {1'b1, (done_d ? LOADER_ACK : LOADER_NAK), 1'b0};
        tx_bit_q  <= '0;
        tx_cnt_q  <= '0;
        tx_busy_q <= 1'b1;
      end
    end else if (tx_cnt_q == TxFullM1) begin
      tx_cnt_q <= '0;
      tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
      if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
      else                  tx_bit_q  <= tx_bit_q + 4'd1;
    end else begin
      tx_cnt_q <= tx_cnt_q + TxCntW'(1);
    end
  end

  assign tx_o = tx_sh_q[0];
`else
  logic unused_nak;
  assign unused_nak = nak_d;
  assign tx_o       = 1'b1;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;

  localparam int unsigned CLK_FREQ     = 1843200;
  localparam int unsigned BAUD         = 115200;
  localparam int unsigned BAUD_DIV     = 16;
  localparam int unsigned BYTE_TIMEOUT = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_i;
  logic        tx_o, we_o, busy_o, done_o, err_o;
  logic [31:0] addr_o, data_o;

  uart_prog_loader #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .BYTE_TIMEOUT(BYTE_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_i  (rx_i),
    .tx_o  (tx_o),
    .we_o  (we_o),
    .addr_o(addr_o),
    .data_o(data_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int   total = 0;
  int   bad = 0;
  int   we_cnt = 0;
  int   done_cnt = 0;
  wr_t  exp_q[$];
  logic [7:0] frame[$];
  logic [7:0] tx_got[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] frame_csum();
    logic [7:0] c;
    c = 8'h00;
    for (int i = 1; i < frame.size(); i++) c ^= frame[i];
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
    rx_i = stop;
    repeat (BAUD_DIV) @(negedge clk);
    rx_i = 1'b1;
    if (!stop) repeat (BAUD_DIV) @(negedge clk);
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], 1'b1);
  endtask

  task automatic check_tx(input string tag, input logic [7:0] exp);
`ifdef LOADER_TX_ACK_EN
    check({tag, "_present"}, 32'(tx_got.size() != 0), 32'd1);
    if (tx_got.size() != 0) check(tag, {24'd0, tx_got.pop_front()}, {24'd0, exp});
`else
    check(tag, {31'd0, tx_o}, 32'd1);
`endif
  endtask

  // Write monitor: every we_o pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (we_o) begin
        we_cnt++;
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr", addr_o, e.addr);
          check("write_data", data_o, e.data);
        end
      end
      if (done_o) done_cnt++;
    end
  end

`ifdef LOADER_TX_ACK_EN
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx_o);
      repeat (BAUD_DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD_DIV) @(negedge clk);
        b[i] = tx_o;
      end
      repeat (BAUD_DIV) @(negedge clk);
      tx_got.push_back(b);
    end
  end
`endif

  initial begin
    rst  = 1'b0;
    rx_i = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_we", {31'd0, we_o}, 32'd0);
    check("rst_addr", addr_o, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_tx", {31'd0, tx_o}, 32'd1);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // Single word at address 0.
    we_cnt = 0; done_cnt = 0;
    exp_q.push_back(wr_t'{32'h0000_0000, 32'h0000_0013});
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
              8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    send_frame();
    repeat (400) @(negedge clk);
    check("t1_writes", we_cnt, 1);
    check("t1_done", done_cnt, 1);
    check("t1_err", {31'd0, err_o}, 32'd0);
    check("t1_busy", {31'd0, busy_o}, 32'd0);
    check("t1_drained", exp_q.size(), 0);
    check_tx("t1_ack", 8'h06);

    // Two words, unaligned base address has its low bits dropped.
    we_cnt = 0; done_cnt = 0;
    exp_q.push_back(wr_t'{32'h0000_0100, 32'hDEAD_BEEF});
    exp_q.push_back(wr_t'{32'h0000_0104, 32'h1234_5678});
    frame = '{8'hA5, 8'h03, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00,
              8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    frame.push_back(frame_csum());
    send_frame();
    repeat (400) @(negedge clk);
    check("t2_writes", we_cnt, 2);
    check("t2_done", done_cnt, 1);
    check("t2_addr_after", addr_o, 32'h0000_0108);
    check("t2_drained", exp_q.size(), 0);
    check_tx("t2_ack", 8'h06);

    // Bad checksum: write still lands, error and no done.
    we_cnt = 0; done_cnt = 0;
    exp_q.push_back(wr_t'{32'h0000_0000, 32'h0000_0013});
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
              8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send_frame();
    repeat (400) @(negedge clk);
    check("t3_writes", we_cnt, 1);
    check("t3_done", done_cnt, 0);
    check("t3_err", {31'd0, err_o}, 32'd1);
    check("t3_drained", exp_q.size(), 0);
    check_tx("t3_nak", 8'h15);

    // Zero-length frame.
    we_cnt = 0; done_cnt = 0;
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame();
    repeat (400) @(negedge clk);
    check("t4_writes", we_cnt, 0);
    check("t4_done", done_cnt, 1);
    check("t4_err", {31'd0, err_o}, 32'd0);
    check_tx("t4_ack", 8'h06);

    // Inter-byte timeout, then recovery by a good frame.
    frame = '{8'hA5, 8'h00, 8'h00};
    send_frame();
    repeat (20) @(negedge clk);
    check("t5_busy_stalled", {31'd0, busy_o}, 32'd1);
    repeat (BYTE_TIMEOUT + 200) @(negedge clk);
    check("t5_busy_timeout", {31'd0, busy_o}, 32'd0);
    check("t5_err_timeout", {31'd0, err_o}, 32'd1);
    check_tx("t5_nak", 8'h15);
    we_cnt = 0; done_cnt = 0;
    send_byte(8'hA5, 1'b1);
    repeat (40) @(negedge clk);
    check("t5_err_cleared", {31'd0, err_o}, 32'd0);
    check("t5_busy_hdr", {31'd0, busy_o}, 32'd1);
    frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame();
    repeat (400) @(negedge clk);
    check("t5_done", done_cnt, 1);
    check("t5_writes", we_cnt, 0);
    check_tx("t5_ack", 8'h06);

    // Framing error inside DATA aborts the frame.
    we_cnt = 0; done_cnt = 0;
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    send_frame();
    send_byte(8'h11, 1'b0);
    repeat (400) @(negedge clk);
    check("t6_busy", {31'd0, busy_o}, 32'd0);
    check("t6_err", {31'd0, err_o}, 32'd1);
    check("t6_writes", we_cnt, 0);
    check("t6_done", done_cnt, 0);
    check_tx("t6_nak", 8'h15);

    // Asynchronous reset mid-frame, after one word has been written.
    we_cnt = 0; done_cnt = 0;
    exp_q.push_back(wr_t'{32'h0000_0004, 32'h0000_0013});
    frame = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h13, 8'h00, 8'h00, 8'h00};
    send_frame();
    repeat (20) @(negedge clk);
    check("t7_busy_pre", {31'd0, busy_o}, 32'd1);
    check("t7_data_pre", data_o, 32'h0000_0013);
    check("t7_writes", we_cnt, 1);
    #2 rst = 1'b0;
    #1;
    check("t7_rst_busy", {31'd0, busy_o}, 32'd0);
    check("t7_rst_addr", addr_o, 32'd0);
    check("t7_rst_data", data_o, 32'd0);
    check("t7_rst_we", {31'd0, we_o}, 32'd0);
    check("t7_rst_err", {31'd0, err_o}, 32'd0);
    check("t7_rst_done", {31'd0, done_o}, 32'd0);
    check("t7_rst_tx", {31'd0, tx_o}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    we_cnt = 0; done_cnt = 0;
    exp_q.push_back(wr_t'{32'h0000_0000, 32'h0000_0013});
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
              8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    send_frame();
    repeat (400) @(negedge clk);
    check("t7_after_done", done_cnt, 1);
    check("t7_after_writes", we_cnt, 1);
    check("t7_drained", exp_q.size(), 0);
    check_tx("t7_ack", 8'h06);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Serial program loader upstream of the instruction ROM. It receives a framed program image over a UART RX line and assembles little-endian 32-bit words. It drives the ROM write port (write enable, address, data) one word at a time. busy_o holds the core in halt while a frame is in flight.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD, integer-truncated, must be >= 4
BYTE_TIMEOUT, 1000000, max idle cycles between bytes inside a frame before abort

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low (`RstEnable = 1'b0)
rx_i  in  1  UART receive line, idle high, asynchronous to clk
tx_o  out  1  UART transmit line (ACK/NAK); constant 1 when feature disabled
we_o  out  1  ROM write enable (`WriteEnable when asserted), single-cycle pulse per word
addr_o  out  32  ROM byte address (`MemAddrBus), bits [1:0] always 0
data_o  out  32  ROM write data (`MemBus)
busy_o  out  1  frame in progress (any state other than IDLE)
done_o  out  1  one-cycle pulse: frame completed, checksum good
err_o  out  1  sticky error flag; cleared on next accepted header byte

Behaviour:
- Reset (rst low, asynchronous): we_o=0, addr_o=0, data_o=0, busy_o=0, done_o=0, err_o=0, tx_o=1. FSM goes to IDLE, all counters 0. Reset mid-frame discards the frame; words already written stay in ROM.
- RX: 2-FF synchronizer on rx_i. A falling edge in line-idle arms the start bit. Start is rechecked low at BAUD_DIV/2; a high there is a glitch and RX returns to idle. Each bit is then sampled every BAUD_DIV cycles, 8 data bits LSB first, then the stop bit. A stop bit of 0 is a framing error: the byte is dropped, and inside a frame the frame aborts with err_o=1. byte_valid pulses 1 cycle after the stop-bit sample.
- Frame format: 0xA5 | ADDR[4] LE | CNT[2] LE | DATA[4*CNT] (each word LE) | CSUM[1]. CSUM = XOR of every byte after the header, excluding CSUM itself.
- FSM states: IDLE, ADDR, CNT, DATA, CSUM.
  - IDLE: bytes other than 0xA5 are ignored. 0xA5 -> ADDR, clears err_o and csum_acc.
  - ADDR: 4 bytes captured. addr_o = {addr[31:2],2'b00}; low bits are ignored, not an error. -> CNT.
  - CNT: 2 bytes captured. CNT=0 -> CSUM directly, otherwise -> DATA.
  - DATA: on the 4th byte of a word, data_o is updated and we_o is asserted the next cycle for exactly 1 cycle. addr_o is held during that pulse and advances by 4 the cycle after. The address wraps modulo 2^32. After CNT words -> CSUM.
  - CSUM: received byte == csum_acc -> done_o pulse. Mismatch -> err_o=1. Either way -> IDLE.
- Writes are committed before the checksum is known. err_o tells the host to resend the frame.
- Timeout: in any non-IDLE state, BYTE_TIMEOUT cycles with no byte_valid -> IDLE, err_o=1. The counter resets on each byte_valid.
- Each byte takes >= 10*BAUD_DIV cycles, so consecutive we_o pulses are never closer than that. No backpressure from the ROM is needed.
- busy_o is combinationally (state != IDLE).

Optional Feature:
Macro LOADER_TX_ACK_EN.
- Defined: an 8N1 UART TX at BAUD sends 0x06 (ACK) on done_o or 0x15 (NAK) on any frame abort or CSUM mismatch. A request arriving while TX is busy is dropped. TX completes independently of the RX FSM.
- Undefined: no TX logic is built; tx_o is tied to 1.

Decomposition:
- Shared defines file gets: LOADER_HDR 8'hA5, LOADER_ACK 8'h06, LOADER_NAK 8'h15, FSM state encodings (3-bit). Existing `RstEnable, `WriteEnable, `MemAddrBus, `MemBus are reused.
- Sub-module uart_rx (synchronizer, bit timing, byte_valid/byte_data/frame_err) is instantiated once.
- The optional TX stays inline under the macro.

Test Plan:
- Use BAUD_DIV=16 (CLK_FREQ=1843200, BAUD=115200). Send A5 00 00 00 00 01 00 13 00 00 00 12 -> one we_o pulse with addr_o=0x00000000, data_o=0x00000013; done_o pulse; err_o=0; ACK 0x06 on tx_o when enabled.
- Send A5 03 01 00 00 02 00 then 8 data bytes, then the correct CSUM -> writes at 0x00000100 then 0x00000104 (low bits dropped), exactly 2 we_o pulses.
- Send the same frame as test 1 with CSUM 0x13 -> the write still occurs; err_o=1, no done_o; NAK 0x15 when enabled.
- Send A5 00 00 00 00 00 00 00 -> zero writes, done_o pulse.
- Send A5 00 00 then stall > BYTE_TIMEOUT -> busy_o falls, err_o=1. A following good frame clears err_o at its header.
- Send a byte with stop bit 0 mid-DATA -> abort, err_o=1. Assert rst low mid-frame -> all outputs return to reset values immediately.
